// File: rtl/psx_state_loader.sv
// psx_state_loader: parses framed controller-state packets from a byte stream
// and commits a verified payload to the state RAM one byte per cycle.
module psx_state_loader #(
  parameter int MAX_BYTES    = 18,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [4:0] write_addr,
  output logic [7:0] write_data,
  output logic       write_en,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_DATA,
    S_CHK,
    S_COMMIT
  } state_t;

  localparam logic [7:0] MAX8 = 8'(MAX_BYTES);
  localparam logic [TIMEOUT_BITS-1:0] T_ONE = TIMEOUT_BITS'(1);
  // Last idle count before the counter saturates; an idle edge here aborts.
  localparam logic [TIMEOUT_BITS-1:0] T_LAST = ~T_ONE;

  state_t state, state_n;

  logic [5:0] len, len_n;
  logic [5:0] idx, idx_n;
  logic [5:0] cidx, cidx_n;
  logic [7:0] xsum, xsum_n;
  logic [TIMEOUT_BITS-1:0] tcnt, tcnt_n;

  logic       wen_n, ok_n, err_n, busy_n;
  logic [4:0] waddr_n;
  logic [7:0] wdata_n;
  logic       shadow_we;
  logic       accept;

  logic [7:0] shadow [MAX_BYTES];

  assign in_ready = (state != S_COMMIT);
  assign accept   = in_valid && in_ready;

  // Next-state, datapath updates and next values of registered outputs.
  always_comb begin
    state_n   = state;
    len_n     = len;
    idx_n     = idx;
    cidx_n    = cidx;
    xsum_n    = xsum;
    tcnt_n    = '0;
    wen_n     = 1'b0;
    waddr_n   = write_addr;
    wdata_n   = write_data;
    ok_n      = 1'b0;
    err_n     = 1'b0;
    shadow_we = 1'b0;

    if ((state == S_LEN || state == S_DATA || state == S_CHK) && !accept) begin
      if (tcnt == T_LAST) begin
        err_n   = 1'b1;
        state_n = S_HUNT;
      end else begin
        tcnt_n = tcnt + T_ONE;
      end
    end

    unique case (state)
      S_HUNT: begin
        if (accept && in_data == 8'hA5)
          state_n = S_LEN;
      end
      S_LEN: begin
        if (accept) begin
          if (in_data == 8'h00 || in_data > MAX8) begin
            err_n   = 1'b1;
            state_n = S_HUNT;
          end else begin
            len_n   = in_data[5:0];
            xsum_n  = in_data;
            idx_n   = '0;
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          shadow_we = 1'b1;
          xsum_n    = xsum ^ in_data;
          idx_n     = idx + 6'd1;
          if (idx + 6'd1 == len)
            state_n = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (in_data == xsum) begin
            state_n = S_COMMIT;
            wen_n   = 1'b1;
            waddr_n = 5'd0;
            wdata_n = shadow[5'd0];
            cidx_n  = 6'd1;
          end else begin
            err_n   = 1'b1;
            state_n = S_HUNT;
          end
        end
      end
      S_COMMIT: begin
        if (cidx == len) begin
          ok_n    = 1'b1;
          state_n = S_HUNT;
        end else begin
          wen_n   = 1'b1;
          waddr_n = cidx[4:0];
          wdata_n = shadow[cidx[4:0]];
          cidx_n  = cidx + 6'd1;
        end
      end
      default: state_n = S_HUNT;
    endcase

    busy_n = (state_n != S_HUNT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HUNT;
      len        <= '0;
      idx        <= '0;
      cidx       <= '0;
      xsum       <= '0;
      tcnt       <= '0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      idx        <= idx_n;
      cidx       <= cidx_n;
      xsum       <= xsum_n;
      tcnt       <= tcnt_n;
      write_en   <= wen_n;
      write_addr <= waddr_n;
      write_data <= wdata_n;
      frame_ok   <= ok_n;
      frame_err  <= err_n;
      busy       <= busy_n;
    end
  end

  // Shadow buffer capture; unreset since only staged entries are read.
  always_ff @(posedge clk) begin
    if (shadow_we)
      shadow[idx[4:0]] <= in_data;
  end

endmodule

// File: tb/tb_psx_state_loader.sv
// tb_psx_state_loader: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed write/pulse expectations.
module tb_psx_state_loader;

  localparam int MAXB = 18;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] write_addr;
  logic [7:0] write_data;
  logic       write_en;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  psx_state_loader #(.MAX_BYTES(MAXB), .TIMEOUT_BITS(4)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .write_addr(write_addr),
    .write_data(write_data),
    .write_en(write_en),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: gathers a whole frame, then decides.
  logic        e_ready = 1'b1;
  logic        e_busy  = 1'b0;
  logic        e_wen   = 1'b0;
  logic        e_ok    = 1'b0;
  logic        e_err   = 1'b0;
  logic [4:0]  e_addr  = '0;
  logic [7:0]  e_data  = '0;
  bit          in_frame;
  bit          pend_ok;
  int          idle;
  byte unsigned fb[$];
  logic [12:0] cq[$];

  task automatic model_byte(input byte unsigned b);
    byte unsigned x;
    int n;
    if (!in_frame) begin
      if (b == 8'hA5) begin
        in_frame = 1;
        fb.delete();
        idle = 0;
      end
    end else begin
      fb.push_back(b);
      idle = 0;
      n = fb[0];
      if (fb.size() == 1 && (n == 0 || n > MAXB)) begin
        e_err = 1'b1;
        in_frame = 0;
      end else if (fb.size() == n + 2) begin
        x = 0;
        for (int i = 0; i <= n; i++) x ^= fb[i];
        if (x == b) begin
          for (int i = 0; i < n; i++) cq.push_back({5'(i), fb[i+1]});
          {e_addr, e_data} = cq.pop_front();
          e_wen = 1'b1;
          pend_ok = 1;
        end else begin
          e_err = 1'b1;
        end
        in_frame = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    bit acc;
    acc = in_valid && e_ready;
    if (reset) begin
      in_frame = 0; pend_ok = 0; idle = 0;
      fb.delete(); cq.delete();
      e_ready = 1'b1; e_busy = 1'b0; e_wen = 1'b0;
      e_ok = 1'b0; e_err = 1'b0; e_addr = '0; e_data = '0;
    end else begin
      e_ok = 1'b0;
      e_err = 1'b0;
      e_wen = 1'b0;
      if (cq.size() > 0) begin
        {e_addr, e_data} = cq.pop_front();
        e_wen = 1'b1;
      end else if (pend_ok) begin
        e_ok = 1'b1;
        pend_ok = 0;
      end
      if (acc) model_byte(in_data);
      else if (in_frame) begin
        idle++;
        if (idle == 15) begin
          e_err = 1'b1;
          in_frame = 0;
        end
      end
      e_ready = (cq.size() == 0) && !pend_ok;
      e_busy = in_frame || !e_ready;
    end
  end

  // Per-cycle comparison against the model.
  bit started = 0;
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("write_en", write_en, e_wen);
      chk("frame_ok", frame_ok, e_ok);
      chk("frame_err", frame_err, e_err);
      if (e_wen) begin
        chk("write_addr", write_addr, e_addr);
        chk("write_data", write_data, e_data);
      end
    end
  end

  // Event monitor for the directed literal expectations.
  int nw, nok, nerr, nlow;
  logic [4:0] wa [64];
  logic [7:0] wd [64];
  always @(negedge clk) begin
    if (write_en && nw < 64) begin
      wa[nw] = write_addr;
      wd[nw] = write_data;
      nw++;
    end
    if (frame_ok) nok++;
    if (frame_err) nerr++;
    if (!in_ready) nlow++;
  end

  task automatic clr();
    nw = 0; nok = 0; nerr = 0; nlow = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_wait", 32'(n), 32'd0);
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic good3();
    send(8'hA5); send(8'h03); send(8'h10); send(8'h20); send(8'h30);
    send(8'h03);
  endtask

  task automatic chk_w(input int i, input logic [4:0] a, input logic [7:0] d);
    chk($sformatf("w%0d_addr", i), wa[i], a);
    chk($sformatf("w%0d_data", i), wd[i], d);
  endtask

  initial begin
    byte unsigned x;
    int n;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    clr();
    repeat (3) @(posedge clk);
    #1;
    started = 1;
    chk("rst_write_en", write_en, 1'b0);
    chk("rst_write_addr", write_addr, 5'd0);
    chk("rst_write_data", write_data, 8'd0);
    chk("rst_frame_ok", frame_ok, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Good frame.
    clr();
    good3(); drop(); settle(8);
    chk("good_nw", nw, 3);
    chk_w(0, 5'd0, 8'h10); chk_w(1, 5'd1, 8'h20); chk_w(2, 5'd2, 8'h30);
    chk("good_ok", nok, 1);
    chk("good_low", nlow, 3);
    chk("good_err", nerr, 0);

    // Bad checksum, then a good frame.
    clr();
    send(8'hA5); send(8'h03); send(8'h10); send(8'h20); send(8'h30);
    send(8'h04); drop(); settle(4);
    chk("badchk_nw", nw, 0);
    chk("badchk_err", nerr, 1);
    good3(); drop(); settle(8);
    chk("after_bad_nw", nw, 3);
    chk("after_bad_ok", nok, 1);

    // Length bounds.
    clr();
    send(8'hA5); send(8'h00); drop(); settle(3);
    chk("len0_err", nerr, 1);
    send(8'hA5); send(8'd19); drop(); settle(3);
    chk("len19_err", nerr, 2);
    chk("len_bad_nw", nw, 0);
    clr();
    x = 8'd18;
    send(8'hA5); send(8'd18);
    for (int i = 0; i < 18; i++) begin
      send(8'(i * 13 + 7));
      x ^= 8'(i * 13 + 7);
    end
    send(x); drop(); settle(24);
    chk("len18_nw", nw, 18);
    for (int i = 0; i < 18; i++) chk_w(i, 5'(i), 8'(i * 13 + 7));
    chk("len18_ok", nok, 1);
    chk("len18_low", nlow, 18);

    // Garbage and in-frame sync bytes.
    clr();
    send(8'h00); send(8'hFF); send(8'h5A);
    send(8'hA5); send(8'h02); send(8'hA5); send(8'hA5); send(8'h02);
    drop(); settle(6);
    chk("sync_err", nerr, 0);
    chk("sync_nw", nw, 2);
    chk_w(0, 5'd0, 8'hA5); chk_w(1, 5'd1, 8'hA5);
    chk("sync_ok", nok, 1);

    // Timeout: 15 idle edges after the first payload byte.
    clr();
    send(8'hA5); send(8'h02); send(8'h11); drop();
    repeat (14) @(negedge clk);
    settle(2);
    chk("tmo_err", nerr, 1);
    chk("tmo_nw", nw, 0);
    chk("tmo_busy", busy, 1'b0);
    // Byte on the saturation edge keeps the frame alive.
    clr();
    send(8'hA5); send(8'h02); send(8'h11); drop();
    repeat (13) @(negedge clk);
    send(8'h22); send(8'h31); drop(); settle(6);
    chk("tmo_save_err", nerr, 0);
    chk("tmo_save_nw", nw, 2);
    chk_w(0, 5'd0, 8'h11); chk_w(1, 5'd1, 8'h22);
    chk("tmo_save_ok", nok, 1);

    // Valid held through COMMIT: next frame waits for in_ready.
    clr();
    good3();
    send(8'hA5); send(8'h01); send(8'h5C); send(8'h5D);
    drop(); settle(6);
    chk("bp_nw", nw, 4);
    chk_w(3, 5'd0, 8'h5C);
    chk("bp_ok", nok, 2);
    chk("bp_err", nerr, 0);

    // Reset on the second commit write.
    clr();
    good3(); drop();
    n = 0;
    while (!(write_en && write_addr == 5'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait", (n < 20), 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_wen", write_en, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    settle(6);
    chk("mid_rst_ok", nok, 0);
    chk("mid_rst_nw", nw, 2);
    clr();
    good3(); drop(); settle(8);
    chk("post_rst_nw", nw, 3);
    chk("post_rst_ok", nok, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
